// File: rtl/alu_pkg.sv
// Shared ALU definitions: NZCV bit positions, ARM condition codes and commit-stage buffer states.
package alu_pkg;

    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    localparam logic [3:0] EQ = 4'd0;
    localparam logic [3:0] NE = 4'd1;
    localparam logic [3:0] CS = 4'd2;
    localparam logic [3:0] CC = 4'd3;
    localparam logic [3:0] MI = 4'd4;
    localparam logic [3:0] PL = 4'd5;
    localparam logic [3:0] VS = 4'd6;
    localparam logic [3:0] VC = 4'd7;
    localparam logic [3:0] HI = 4'd8;
    localparam logic [3:0] LS = 4'd9;
    localparam logic [3:0] GE = 4'd10;
    localparam logic [3:0] LT = 4'd11;
    localparam logic [3:0] GT = 4'd12;
    localparam logic [3:0] LE = 4'd13;
    localparam logic [3:0] AL = 4'd14;
    localparam logic [3:0] NV = 4'd15;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_commit_stage_if.sv
// Upstream ALU-result channel and downstream writeback channel of the commit stage.
interface alu_commit_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] result;
    logic [3:0]        new_flag;
    logic              s;
    logic [3:0]        cond;
    logic [RD_W-1:0]   rd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_write;

    modport master (
        output in_valid, result, new_flag, s, cond, rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_write
    );

    modport slave (
        input  in_valid, result, new_flag, s, cond, rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_write
    );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against NZCV; shared with the branch unit.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flag[N];
    assign z = flag[Z];
    assign c = flag[C];
    assign v = flag[V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_commit_stage.sv
// Commits or annuls ALU results by condition code, owns architectural NZCV, retire/annul counters.
// Entry visible on out_* the cycle after accept; 2-entry skid buffer, in_ready depends on state only.
module alu_commit_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_commit_stage_if.slave   bus,
    output logic [3:0]          flag,
    output logic [31:0]         retired,
    output logic [15:0]         annulled
);
    skid_state_t       state, state_nxt;

    logic [DATA_W-1:0] head_result, tail_result;
    logic [RD_W-1:0]   head_rd, tail_rd;
    logic              head_pass, tail_pass;

    logic pass;
    logic push;
    logic pop;
    logic load_head_in;
    logic load_tail_in;
    logic move_tail;

    cond_check u_cond_check (
        .cond (bus.cond),
        .flag (flag),
        .pass (pass)
    );

    assign push = bus.in_valid & bus.in_ready & ~rst;
    assign pop  = bus.out_valid & bus.out_ready;

    assign bus.in_ready   = (state != TWO);
    assign bus.out_valid  = (state != EMPTY);
    assign bus.out_result = head_result;
    assign bus.out_rd     = head_rd;
    assign bus.out_write  = head_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_head_in = 1'b0;
        load_tail_in = 1'b0;
        move_tail    = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt    = TWO;
                    load_tail_in = 1'b1;
                end else if (!push && pop) begin
                    state_nxt    = EMPTY;
                end else if (push && pop) begin
                    load_head_in = 1'b1;
                end
            end
            TWO: begin
                // in_ready is low here, so a pop can only promote the tail
                if (pop) begin
                    state_nxt = ONE;
                    move_tail = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_result <= '0;
            head_rd     <= '0;
            head_pass   <= 1'b0;
        end else if (load_head_in) begin
            head_result <= bus.result;
            head_rd     <= bus.rd;
            head_pass   <= pass;
        end else if (move_tail) begin
            head_result <= tail_result;
            head_rd     <= tail_rd;
            head_pass   <= tail_pass;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_result <= '0;
            tail_rd     <= '0;
            tail_pass   <= 1'b0;
        end else if (load_tail_in) begin
            tail_result <= bus.result;
            tail_rd     <= bus.rd;
            tail_pass   <= pass;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= 4'b0000;
        end else if (push && pass && bus.s) begin
            flag <= bus.new_flag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired  <= '0;
            annulled <= '0;
        end else if (push) begin
            if (pass) begin
                retired <= retired + 32'd1;
            end else if (annulled != 16'hFFFF) begin
                annulled <= annulled + 16'd1;
            end
        end
    end
endmodule

// File: doc/alu_commit_stage.md
# alu_commit_stage

Execute-side commit stage directly downstream of the ALU arithmetic units (SUB and siblings). Each cycle it can accept one ALU result with its candidate NZCV flags, evaluates the instruction's condition code against the architectural flag register, and commits or annuls the result. It owns the architectural NZCV register that feeds back to the ALU `Flag` input, and buffers committed results in a 2-entry skid buffer toward register-file writeback.

## Interface
- DATA_W, 32, result width
- RD_W, 4, destination register index width
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- In_Valid  in  1  upstream ALU result valid
- In_Ready  out  1  stage can accept this cycle
- Result  in  DATA_W  ALU result, signed
- New_Flag  in  4  candidate flags {N,Z,C,V}, bit 3 = N
- S  in  1  instruction updates flags
- Cond  in  4  ARM-style condition code
- Rd  in  RD_W  destination register
- Flag  out  4  architectural NZCV, fed to ALU Flag input
- Out_Valid  out  1  writeback entry valid
- Out_Ready  in  1  writeback accepts
- Out_Result  out  DATA_W  committed result
- Out_Rd  out  RD_W  destination register
- Out_Write  out  1  1 = write Rd; 0 = annulled, no write
- Retired  out  32  count of accepted entries that passed Cond
- Annulled  out  16  count of accepted entries that failed Cond, saturating at 16'hFFFF

## Operation
- Accept = In_Valid & In_Ready & !Rst.
- On accept, `cond_check(Cond, Flag)` gives pass. Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Pass & S: Flag <= New_Flag at the accepting edge. Fail or !S: Flag unchanged.
- Every accepted entry is pushed {Result, Rd, pass} into the skid buffer. Out_Write = pass. Failed entries still drain so writeback sees in-order slots.
- Retired increments on pass, wraps at 2^32. Annulled increments on fail, holds at 16'hFFFF.
- Skid buffer FSM: EMPTY, ONE, TWO. Push = accept; Pop = Out_Valid & Out_Ready.
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> TWO; !push & pop -> EMPTY; push & pop -> ONE, new entry replaces the head.
  - TWO: pop -> ONE, second entry moves to the head. No push is possible.
- In_Ready = (state != TWO), registered from state with no combinational path from Out_Ready.
- Out_Valid = (state != EMPTY). Out_* show the head entry and hold stable while Out_Valid & !Out_Ready.

## Timing
- Latency: accept at edge k gives Out_Valid high after edge k, with head data valid in the same cycle.
- Flag update is visible on `Flag` the cycle after accept. A back-to-back accepted instruction evaluates Cond against the updated Flag. There is no same-cycle bypass.
- Throughput: 1 per cycle while Out_Ready is held high.
- Reset (asynchronous, any time, including mid-transfer): state EMPTY, buffer contents discarded, Flag = 4'b0000, Out_Valid = 0, Out_Write = 0, Out_Result = 0, Out_Rd = 0, In_Ready = 1, Retired = 0, Annulled = 0. Inputs are ignored while Rst is high. The first accept can happen on the first rising edge after Rst is released.

## Structure
- Shared package `alu_pkg` holds:
  - NZCV bit-index constants: N = 3, Z = 2, C = 1, V = 0.
  - Condition-code localparams EQ through NV.
  - Skid-buffer state enum {EMPTY, ONE, TWO}.
- Sub-module `cond_check`: purely combinational, (Cond[3:0], Flag[3:0]) -> pass. It is shared with the branch unit.
- The top holds the FSM, two entry registers, the flag register and the counters.

## Test plan
- Reset, then accept Result = 32'h0000_0005, Cond = AL, S = 1, New_Flag = 4'b0010 -> next cycle Out_Valid = 1, Out_Result = 5, Out_Write = 1, Flag = 4'b0010, Retired = 1.
- Flag = 4'b0100 (Z), accept Cond = NE, S = 1, New_Flag = 4'b1000 -> Out_Write = 0, Flag stays 4'b0100, Annulled = 1.
- Out_Ready = 0, three consecutive In_Valid cycles -> entries 1 and 2 buffered, In_Ready low from the 3rd cycle, entry 3 held upstream. Raise Out_Ready -> outputs appear in order 1, 2, 3 with no loss or duplication.
- Back-to-back: first accept (S = 1, New_Flag Z = 1), then Cond = EQ on the next cycle -> second entry passes.
- Assert Rst with state TWO and Flag = 4'b1111 -> immediately Out_Valid = 0, In_Ready = 1, Flag = 0, counters 0.
- 65,540 consecutive NV entries with Out_Ready = 1 -> Annulled = 16'hFFFF, Retired = 0, one entry per cycle.
